btn_cmd_frontend: RTL

BTN_CMD_FRONTEND -- requirements
Module: btn_cmd_frontend

---
 rtl/btn_cmd_frontend.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/btn_cmd_frontend.sv
// Button/switch front end: synchronize, debounce (optional, macro BTN_DEBOUNCE_EN),
// detect presses, and queue prioritized commands into a small ready/valid FIFO.
module btn_cmd_frontend #(
    parameter int CLK_FREQ    = 100,
    parameter int DEBOUNCE_US = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [4:0]  btn,
    input  logic [15:0] sw,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_code,
    output logic [15:0] cmd_data,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] C_INIT  = 2'd0;
    localparam logic [1:0] C_ADD   = 2'd1;
    localparam logic [1:0] C_SPEED = 2'd2;
    localparam logic [1:0] C_CLEAR = 2'd3;

    typedef struct packed {
        logic [1:0]  code;
        logic [15:0] data;
    } cmd_t;

    logic [4:0]       btn_s1, btn_s2, db, db_q, rise;
    logic [15:0]      sw_s1, sw_s2;
    logic [3:0]       rise_c, pend, sel;
    logic [1:0]       sel_code;
    logic [3:0][15:0] payload;
    cmd_t             mem [FIFO_DEPTH];
    cmd_t             wdata, head;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_req, full, pop, wr_en, drop, repress, ovf;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int DEBOUNCE_CYCLES = CLK_FREQ * DEBOUNCE_US;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [4:0][DW-1:0] db_cnt;

    // Level flips only after DEBOUNCE_CYCLES back-to-back disagreeing samples.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            db     <= '0;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (btn_s2[i] != db[i]) begin
                    if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        db[i]     <= btn_s2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign db = btn_s2;
`endif

    always_ff @(posedge clk_sys) begin
        if (rst) db_q <= '0;
        else     db_q <= db;
    end

    assign rise   = db & ~db_q;
    // Pending/payload slots are indexed by command code; BTNR (bit 3) is ignored.
    assign rise_c = {rise[4], rise[2], rise[1], rise[0]};

    always_comb begin
        sel      = 4'b0000;
        sel_code = C_INIT;
        if (pend[C_INIT]) begin
            sel      = 4'b0001;
            sel_code = C_INIT;
        end else if (pend[C_CLEAR]) begin
            sel      = 4'b1000;
            sel_code = C_CLEAR;
        end else if (pend[C_SPEED]) begin
            sel      = 4'b0100;
            sel_code = C_SPEED;
        end else if (pend[C_ADD]) begin
            sel      = 4'b0010;
            sel_code = C_ADD;
        end
    end

    assign wr_req  = |pend;
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = cmd_valid & cmd_ready;
    assign wr_en   = wr_req & (~full | pop);
    assign drop    = wr_req & full & ~pop;
    // A slot selected this cycle is leaving, so a new press into it is not a re-press.
    assign repress = |(rise_c & pend & ~sel);
    assign wdata   = '{code: sel_code, data: payload[sel_code]};

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            pend    <= '0;
            payload <= '0;
            ovf     <= 1'b0;
        end else begin
            pend <= (pend & ~sel) | rise_c;
            payload[C_INIT]  <= '0;
            payload[C_CLEAR] <= '0;
            if (rise_c[C_ADD])   payload[C_ADD]   <= {11'b0, sw_s2[4:0]};
            if (rise_c[C_SPEED]) payload[C_SPEED] <= sw_s2;
            if (drop || repress) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign cmd_valid = (count != '0);
    assign cmd_code  = cmd_valid ? head.code : 2'd0;
    assign cmd_data  = cmd_valid ? head.data : 16'd0;
    assign overflow  = ovf;

endmodule
